// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
//   in_valid/in_ready/in_data : valid/ready byte stream into the loader
//   imem_we/imem_addr/imem_wdata : one-cycle word write into instruction memory
// modport slave is the loader side; modport master is the source/memory side.
interface imem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: consumes a length-prefixed big-endian byte stream, assembles
// 32-bit instruction words and writes them to consecutive word addresses from 0.
// Holds the core stalled until the load completes.
//   clock, reset  : system clock, synchronous active-high reset
//   start         : one-cycle pulse beginning a load (from IDLE, DONE or ERROR)
//   bus           : byte stream in, instruction-memory write out
//   core_hold     : core stall, low only once a load has completed
//   done / error  : load completed / length header exceeded MAX_WORDS
//   words_loaded  : words written by the current load
module imem_loader #(
  parameter int unsigned MAX_WORDS  = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          core_hold,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_loaded
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [31:0]           word_q, word_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [15:0]           idx_q, idx_d;
  logic [15:0]           wl_q, wl_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  hold_q, hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  fire;
  logic [15:0]           n_full;
  logic [15:0]           idx_inc;

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      wl_q    <= '0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wl_q    <= wl_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wl_d    = wl_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    fire    = bus.in_valid && ready_q;
    n_full  = {len_q[15:8], bus.in_data};
    idx_inc = idx_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (fire) begin
          len_d[15:8] = bus.in_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (fire) begin
          len_d[7:0] = bus.in_data;
          if (n_full == 16'd0) begin
            state_d = S_DONE;
          end else if (n_full > MAX_N) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
            cnt_d   = 2'd0;
            idx_d   = 16'd0;
          end
        end
      end
      S_DATA: begin
        if (fire) begin
          word_d = {word_q[23:0], bus.in_data};
          cnt_d  = cnt_q + 2'd1;
          // Fourth byte: launch the write so imem_we is high during WRITE
          if (cnt_q == 2'd3) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = ADDR_WIDTH'(idx_q);
            wdata_d = {word_q[23:0], bus.in_data};
          end
        end
      end
      S_WRITE: begin
        wl_d = idx_inc;
        if (idx_inc == len_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DATA;
          idx_d   = idx_inc;
        end
      end
      S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_LEN_HI;
          wl_d    = 16'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs follow the state being entered
    ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA);
    hold_d  = (state_d != S_DONE);
    done_d  = (state_d == S_DONE);
    err_d   = (state_d == S_ERROR);
  end

  assign bus.in_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_hold      = hold_q;
  assign done           = done_q;
  assign error          = err_q;
  assign words_loaded   = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of complete loads plus hand-written
// sequences for reset values, latency, start/reset interactions and limits.
module tb_imem_loader;
  localparam int unsigned AW = 32;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        core_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.MAX_WORDS(256), .ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .core_hold    (core_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [95:0] s;
    int          n;
    int          mode;
    int          exp_wr;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        ed;
    logic        ee;
    logic [15:0] ewl;
  } vec_t;

  vec_t        vt[6];
  int          nv = 0;
  int          total = 0;
  int          bad = 0;
  int          wr_cnt, dbl, rdy_we;
  logic        prev_we;
  logic [31:0] mem[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and log memory writes
  task automatic tick();
    @(posedge clock);
    #1;
    if (bus.imem_we === 1'b1) begin
      wr_cnt++;
      if (bus.imem_addr < 32'(16)) mem[bus.imem_addr[3:0]] = bus.imem_wdata;
      if (bus.in_ready !== 1'b0) rdy_we++;
      if (prev_we) dbl++;
    end
    prev_we = (bus.imem_we === 1'b1);
  endtask

  task automatic clear_log();
    wr_cnt  = 0;
    dbl     = 0;
    rdy_we  = 0;
    prev_we = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'hDEADBEEF;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: in_valid held high; mode 1: in_valid toggles every cycle
  task automatic send(input logic [95:0] s, input int n, input int mode);
    int   i = 0;
    int   c = 0;
    logic fire;
    while (i < n && c < 400) begin
      bus.in_valid = (mode == 1) ? ((c % 2) == 0) : 1'b1;
      bus.in_data  = s[95 - 8*i -: 8];
      fire = bus.in_valid && bus.in_ready;
      tick();
      if (fire) i++;
      c++;
    end
    bus.in_valid = 1'b0;
    if (i < n) chk("send_timeout", 32'(i), 32'(n));
  endtask

  task automatic wait_end();
    int c = 0;
    while (!(done || error) && c < 40) begin
      tick();
      c++;
    end
    if (c >= 40) chk("end_timeout", 32'(done || error), 32'd1);
  endtask

  task automatic add(input string nm, input logic [95:0] s, input int n, input int mode,
                     input int exp_wr, input logic [31:0] w0, input logic [31:0] w1,
                     input logic ed, input logic ee, input logic [15:0] ewl);
    vt[nv].name   = nm;
    vt[nv].s      = s;
    vt[nv].n      = n;
    vt[nv].mode   = mode;
    vt[nv].exp_wr = exp_wr;
    vt[nv].w0     = w0;
    vt[nv].w1     = w1;
    vt[nv].ed     = ed;
    vt[nv].ee     = ee;
    vt[nv].ewl    = ewl;
    nv++;
  endtask

  initial begin
    add("basic",    96'h00027C221A147C4322140000, 10, 0, 2, 32'h7C221A14, 32'h7C432214, 1'b1, 1'b0, 16'd2);
    add("gapped",   96'h00027C221A147C4322140000, 10, 1, 2, 32'h7C221A14, 32'h7C432214, 1'b1, 1'b0, 16'd2);
    add("zero_len", 96'h000000000000000000000000,  2, 0, 0, 32'h0,        32'h0,        1'b1, 1'b0, 16'd0);
    add("oversize", 96'h010100000000000000000000,  2, 0, 0, 32'h0,        32'h0,        1'b0, 1'b1, 16'd0);
    add("one_word", 96'h000138200005000000000000,  6, 1, 1, 32'h38200005, 32'h0,        1'b1, 1'b0, 16'd1);

    // Reset values
    do_reset();
    chk("rst.in_ready",  32'(bus.in_ready),   32'd0);
    chk("rst.imem_we",   32'(bus.imem_we),    32'd0);
    chk("rst.imem_addr", 32'(bus.imem_addr),  32'd0);
    chk("rst.wdata",     bus.imem_wdata,      32'd0);
    chk("rst.core_hold", 32'(core_hold),      32'd1);
    chk("rst.done",      32'(done),           32'd0);
    chk("rst.error",     32'(error),          32'd0);
    chk("rst.words",     32'(words_loaded),   32'd0);

    // Table-driven full loads
    for (int k = 0; k < nv; k++) begin
      do_reset();
      clear_log();
      pulse_start();
      chk($sformatf("%s.ready_after_start", vt[k].name), 32'(bus.in_ready), 32'd1);
      send(vt[k].s, vt[k].n, vt[k].mode);
      wait_end();
      chk($sformatf("%s.writes", vt[k].name), 32'(wr_cnt), 32'(vt[k].exp_wr));
      if (vt[k].exp_wr >= 1) chk($sformatf("%s.mem0", vt[k].name), mem[0], vt[k].w0);
      if (vt[k].exp_wr >= 2) chk($sformatf("%s.mem1", vt[k].name), mem[1], vt[k].w1);
      chk($sformatf("%s.untouched", vt[k].name), mem[vt[k].exp_wr], 32'hDEADBEEF);
      chk($sformatf("%s.done", vt[k].name),      32'(done),         32'(vt[k].ed));
      chk($sformatf("%s.error", vt[k].name),     32'(error),        32'(vt[k].ee));
      chk($sformatf("%s.core_hold", vt[k].name), 32'(core_hold),    32'(!vt[k].ed));
      chk($sformatf("%s.in_ready", vt[k].name),  32'(bus.in_ready), 32'd0);
      chk($sformatf("%s.words", vt[k].name),     32'(words_loaded), 32'(vt[k].ewl));
      chk($sformatf("%s.double_we", vt[k].name), 32'(dbl),          32'd0);
      chk($sformatf("%s.ready_in_write", vt[k].name), 32'(rdy_we),  32'd0);
    end

    // Simultaneous reset and start from DONE: reset wins, back to IDLE
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start.in_ready",  32'(bus.in_ready), 32'd0);
    chk("rst_start.done",      32'(done),         32'd0);
    chk("rst_start.core_hold", 32'(core_hold),    32'd1);
    tick();
    chk("rst_start.idle",      32'(bus.in_ready), 32'd0);

    // Write latency: imem_we in the cycle after the 4th byte's edge, one cycle only
    do_reset();
    clear_log();
    pulse_start();
    send(96'h0001AABBCCDD000000000000, 6, 0);
    chk("lat.we",       32'(bus.imem_we),   32'd1);
    chk("lat.addr",     32'(bus.imem_addr), 32'd0);
    chk("lat.wdata",    bus.imem_wdata,     32'hAABBCCDD);
    chk("lat.ready",    32'(bus.in_ready),  32'd0);
    chk("lat.words",    32'(words_loaded),  32'd0);
    tick();
    chk("lat.we_off",   32'(bus.imem_we),   32'd0);
    chk("lat.done",     32'(done),          32'd1);
    chk("lat.words1",   32'(words_loaded),  32'd1);

    // Zero length reaches DONE on the edge that consumed the low length byte
    do_reset();
    pulse_start();
    send(96'h0, 2, 0);
    chk("zero.done_now", 32'(done),      32'd1);
    chk("zero.hold_now", 32'(core_hold), 32'd0);

    // N == MAX_WORDS is accepted
    do_reset();
    pulse_start();
    send(96'h010000000000000000000000, 2, 0);
    chk("max.error", 32'(error),        32'd0);
    chk("max.ready", 32'(bus.in_ready), 32'd1);

    // Oversize, then a fresh start clears error and loads normally
    do_reset();
    clear_log();
    pulse_start();
    send(96'h010100000000000000000000, 2, 0);
    chk("ovr.error",     32'(error),        32'd1);
    chk("ovr.core_hold", 32'(core_hold),    32'd1);
    pulse_start();
    chk("ovr.err_clear", 32'(error),        32'd0);
    chk("ovr.ready",     32'(bus.in_ready), 32'd1);
    send(96'h00027C221A147C4322140000, 10, 0);
    wait_end();
    chk("ovr.writes", 32'(wr_cnt),       32'd2);
    chk("ovr.mem0",   mem[0],            32'h7C221A14);
    chk("ovr.mem1",   mem[1],            32'h7C432214);
    chk("ovr.done",   32'(done),         32'd1);
    chk("ovr.words",  32'(words_loaded), 32'd2);

    // Restart from DONE clears done and words_loaded
    pulse_start();
    chk("restart.done",  32'(done),         32'd0);
    chk("restart.words", 32'(words_loaded), 32'd0);
    chk("restart.hold",  32'(core_hold),    32'd1);

    // Start mid-load is ignored
    do_reset();
    clear_log();
    pulse_start();
    send(96'h00027C22_0000000000000000, 4, 0);
    pulse_start();
    chk("midstart.ready", 32'(bus.in_ready), 32'd1);
    send(96'h1A147C432214000000000000, 6, 1);
    wait_end();
    chk("midstart.writes", 32'(wr_cnt), 32'd2);
    chk("midstart.mem0",   mem[0],      32'h7C221A14);
    chk("midstart.mem1",   mem[1],      32'h7C432214);

    // Reset mid-word discards the partial word
    do_reset();
    clear_log();
    pulse_start();
    send(96'h00017C220000000000000000, 4, 0);
    reset = 1'b1;
    tick();
    chk("rmid.we",    32'(bus.imem_we),  32'd0);
    chk("rmid.hold",  32'(core_hold),    32'd1);
    chk("rmid.ready", 32'(bus.in_ready), 32'd0);
    reset = 1'b0;
    tick();
    chk("rmid.no_write", 32'(wr_cnt), 32'd0);
    pulse_start();
    send(96'h000138200005000000000000, 6, 0);
    wait_end();
    chk("rmid.writes", 32'(wr_cnt), 32'd1);
    chk("rmid.mem0",   mem[0],      32'h38200005);
    chk("rmid.done",   32'(done),   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader: the write side of the instruction memory that the uPower core reads through its instruction-fetch port.
- Accepts a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to consecutive word addresses, starting at 0, matching the core's PC-increments-by-1 addressing.
- Holds the core in stall (core_hold) until the load completes.

Parameters:
- MAX_WORDS, 256, maximum program length in words. Must not exceed 65535.
- ADDR_WIDTH, 32, width of imem_addr. Matches the PC width.

Ports:
- clock  input  1  system clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse that begins a load
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  loader can accept a byte this cycle
- in_data  input  8  stream byte
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  ADDR_WIDTH  word address of the write
- imem_wdata  output  32  assembled instruction word
- core_hold  output  1  stall the core's PC/execution while high
- done  output  1  load completed successfully
- error  output  1  length header exceeded MAX_WORDS
- words_loaded  output  16  number of words written so far

Behaviour:
- All outputs are registered. Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_hold=1, done=0, error=0, words_loaded=0. After reset the state is IDLE.
- Handshake: a byte is consumed on a posedge where in_valid && in_ready. in_data is sampled only on that edge. Bytes offered while in_ready=0 are not consumed, and the source must hold them.
- Stream format:
  - 2-byte big-endian word count N (first byte = N[15:8]).
  - Then N words of 4 bytes each; the first byte of a word goes to bits 31:24.
- States:
  - IDLE: in_ready=0. start -> LEN_HI.
  - LEN_HI: in_ready=1. On a byte: N[15:8] <= byte -> LEN_LO.
  - LEN_LO: in_ready=1. On a byte, N[7:0] <= byte, then:
    - N==0 -> DONE.
    - N>MAX_WORDS -> ERROR.
    - otherwise -> DATA with byte count=0 and word index=0.
  - DATA: in_ready=1. Each byte shifts into the word; the byte count increments modulo 4. On the 4th byte -> WRITE.
  - WRITE: in_ready=0. Exactly one cycle, with imem_we=1, imem_addr=word index, imem_wdata=assembled word. words_loaded <= index+1. If index+1==N -> DONE, else -> DATA.
  - DONE: done=1, core_hold=0, in_ready=0.
  - ERROR: error=1, core_hold=1, in_ready=0. No further writes.
- Latency: imem_we asserts on the cycle after the edge that consumed the 4th byte of a word. Minimum throughput is 5 cycles per word.
- core_hold is 1 in every state except DONE.
- start:
  - Ignored in LEN_HI, LEN_LO, DATA and WRITE.
  - In DONE or ERROR, start clears done, error and words_loaded and goes to LEN_HI. The next load overwrites memory from address 0.
- Reset mid-operation: the partial word is discarded, and imem_we is 0 from the reset edge onward. Words already written to memory are not erased.
- Simultaneous reset and start: reset wins.
- Word index never exceeds N-1, and there is no address wrap.

Test Plan:
- Basic load: reset, start, then bytes 00 02 7C 22 1A 14 7C 43 22 14 with in_valid always high -> two writes: addr0=0x7C221A14, addr1=0x7C432214. Then done=1, core_hold=0, words_loaded=2, in_ready=0.
- Backpressure: in_valid held high through each WRITE cycle -> in_ready=0 during WRITE and the held byte is consumed on the following cycle. Same memory contents as the basic load, with no byte lost or duplicated.
- Gapped source: in_valid toggles 1/0 every cycle, same stream as the basic load -> identical writes and done. imem_we is never asserted twice for one word.
- Zero length: start, bytes 00 00 -> DONE on the next edge, imem_we never asserted, words_loaded=0.
- Oversize: start, bytes 01 01 (257 > 256) -> error=1, core_hold=1, in_ready=0, no writes. A new start followed by a valid stream loads correctly and clears error.
- Reset mid-word: start, 00 01 7C 22, then reset -> IDLE, no write, core_hold=1. Then start with 00 01 38 20 00 05 -> addr0=0x38200005 and done=1.
